// File: rtl/test_vector_engine.sv
// Purpose : vector playback/compare engine; plays drive words to the DUT one per clock and
//           checks the masked response LAT cycles later, counting compares and mismatches.
// Latency : drive for vector a appears 2+a cycles after start; its compare lands LAT cycles later.
// Flow    : no backpressure; loads (i_vec_wr_*) and start are dropped while busy.
// Ports   : i_clk/i_rst (async, active-high); i_vec_wr_* vector load; i_start/i_abort/i_mode/
//           i_num_vectors/i_loop_count run control; o_dut_drive/i_dut_resp DUT side;
//           o_busy/o_done/o_error_count/o_first_err_*/o_compare_count status.
module test_vector_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int LAT    = 2,
  parameter int ERR_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vec_wr_en,
  input  logic [ADDR_W-1:0] i_vec_wr_addr,
  input  logic [DATA_W-1:0] i_vec_wr_drive,
  input  logic [DATA_W-1:0] i_vec_wr_expect,
  input  logic [DATA_W-1:0] i_vec_wr_mask,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  input  logic [ADDR_W:0]   i_num_vectors,
  input  logic [15:0]       i_loop_count,
  output logic [DATA_W-1:0] o_dut_drive,
  input  logic [DATA_W-1:0] i_dut_resp,
  output logic              o_busy,
  output logic              o_done,
  output logic [ERR_W-1:0]  o_error_count,
  output logic              o_first_err_valid,
  output logic [ADDR_W-1:0] o_first_err_addr,
  output logic [31:0]       o_compare_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_W-1:0] r_mem_drv [DEPTH];
  logic [DATA_W-1:0] r_mem_exp [DEPTH];
  logic [DATA_W-1:0] r_mem_msk [DEPTH];

  // Run configuration is captured at start so the control inputs may change mid-run.
  logic [1:0]        r_mode;
  logic [ADDR_W:0]   r_nv;
  logic [15:0]       r_loops;
  logic [15:0]       r_pass;
  logic [ADDR_W-1:0] r_addr;

  // Compare pipeline: entry 0 is the memory read register (same cycle as o_dut_drive),
  // entry LAT is the stage that meets the matching i_dut_resp.
  logic              r_p_vld [LAT+1];
  logic [DATA_W-1:0] r_p_exp [LAT+1];
  logic [DATA_W-1:0] r_p_msk [LAT+1];
  logic [ADDR_W-1:0] r_p_adr [LAT+1];

  logic [DATA_W-1:0] r_drive;
  logic [ERR_W-1:0]  r_err_cnt;
  logic              r_fe_vld;
  logic [ADDR_W-1:0] r_fe_addr;
  logic [31:0]       r_cmp_cnt;

  logic            w_busy;
  logic            w_start;
  logic            w_cmp_vld;
  logic            w_mis;
  logic            w_kill;
  logic            w_issue;
  logic            w_last_addr;
  logic            w_last_pass;
  logic            w_final;
  logic            w_pipe_busy;
  logic [ADDR_W:0] w_nv_m1;

  assign w_busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_cmp_vld   = r_p_vld[LAT];
  assign w_mis       = |((i_dut_resp ^ r_p_exp[LAT]) & r_p_msk[LAT]);
  // Abort or a stop-on-error mismatch ends the run now and flushes everything in flight.
  assign w_kill      = w_busy && (i_abort || (r_mode[1] && w_cmp_vld && w_mis));
  assign w_issue     = (r_state == S_RUN) && !w_kill;
  assign w_nv_m1     = r_nv - (ADDR_W+1)'(1);
  assign w_last_addr = ({1'b0, r_addr} == w_nv_m1);
  // loop_count of 0 in a loop mode means "never the last pass".
  assign w_last_pass = !r_mode[0] || ((r_loops != 16'd0) && (r_pass == r_loops - 16'd1));
  assign w_final     = w_issue && w_last_addr && w_last_pass;

  // Anything still queued ahead of the compare stage keeps DRAIN alive.
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int k = 0; k < LAT; k++) w_pipe_busy = w_pipe_busy | r_p_vld[k];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = w_busy;
    o_done      = (r_state == S_DONE);
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_num_vectors == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_kill) w_state_nxt = S_DONE;
               else if (w_final) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_kill || !w_pipe_busy) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector store: writes are locked out while a run is reading it.
  always_ff @(posedge i_clk) begin
    if (i_vec_wr_en && !w_busy) begin
      r_mem_drv[i_vec_wr_addr] <= i_vec_wr_drive;
      r_mem_exp[i_vec_wr_addr] <= i_vec_wr_expect;
      r_mem_msk[i_vec_wr_addr] <= i_vec_wr_mask;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode  <= '0;
      r_nv    <= '0;
      r_loops <= '0;
      r_pass  <= '0;
      r_addr  <= '0;
    end else if (w_start) begin
      r_mode  <= i_mode;
      r_nv    <= i_num_vectors;
      r_loops <= i_loop_count;
      r_pass  <= '0;
      r_addr  <= '0;
    end else if (w_issue) begin
      // Wrap straight back to 0 so loop passes run back to back without a bubble.
      if (w_last_addr) begin
        r_addr <= '0;
        r_pass <= r_pass + 16'd1;
      end else begin
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drive <= '0;
      for (int k = 0; k <= LAT; k++) begin
        r_p_vld[k] <= 1'b0;
        r_p_exp[k] <= '0;
        r_p_msk[k] <= '0;
        r_p_adr[k] <= '0;
      end
    end else begin
      r_p_vld[0] <= w_issue;
      // o_dut_drive only moves on an issue, so it holds the last driven word afterwards.
      if (w_issue) begin
        r_drive    <= r_mem_drv[r_addr];
        r_p_exp[0] <= r_mem_exp[r_addr];
        r_p_msk[0] <= r_mem_msk[r_addr];
        r_p_adr[0] <= r_addr;
      end
      for (int k = 1; k <= LAT; k++) begin
        r_p_vld[k] <= r_p_vld[k-1] && !w_kill;
        r_p_exp[k] <= r_p_exp[k-1];
        r_p_msk[k] <= r_p_msk[k-1];
        r_p_adr[k] <= r_p_adr[k-1];
      end
    end
  end

  // The compare in the killing cycle still counts; only younger entries are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_cnt <= '0;
      r_fe_vld  <= 1'b0;
      r_fe_addr <= '0;
      r_cmp_cnt <= '0;
    end else if (w_start) begin
      r_err_cnt <= '0;
      r_fe_vld  <= 1'b0;
      r_fe_addr <= '0;
      r_cmp_cnt <= '0;
    end else if (w_cmp_vld) begin
      r_cmp_cnt <= r_cmp_cnt + 32'd1;
      if (w_mis) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_W'(1);
        if (!r_fe_vld) begin
          r_fe_vld  <= 1'b1;
          r_fe_addr <= r_p_adr[LAT];
        end
      end
    end
  end

  assign o_dut_drive       = r_drive;
  assign o_error_count     = r_err_cnt;
  assign o_first_err_valid = r_fe_vld;
  assign o_first_err_addr  = r_fe_addr;
  assign o_compare_count   = r_cmp_cnt;

endmodule

// File: tb/tb_test_vector_engine.sv
module tb_test_vector_engine;

  logic        i_clk;
  logic        i_rst;
  logic        i_vec_wr_en;
  logic [9:0]  i_vec_wr_addr;
  logic [31:0] i_vec_wr_drive;
  logic [31:0] i_vec_wr_expect;
  logic [31:0] i_vec_wr_mask;
  logic        i_start;
  logic        i_abort;
  logic [1:0]  i_mode;
  logic [10:0] i_num_vectors;
  logic [15:0] i_loop_count;
  logic [31:0] o_dut_drive;
  logic [31:0] i_dut_resp;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_error_count;
  logic        o_first_err_valid;
  logic [9:0]  o_first_err_addr;
  logic [31:0] o_compare_count;

  test_vector_engine #(
    .DATA_W(32), .DEPTH(1024), .ADDR_W(10), .LAT(2), .ERR_W(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_vec_wr_en(i_vec_wr_en), .i_vec_wr_addr(i_vec_wr_addr),
    .i_vec_wr_drive(i_vec_wr_drive), .i_vec_wr_expect(i_vec_wr_expect),
    .i_vec_wr_mask(i_vec_wr_mask),
    .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
    .i_num_vectors(i_num_vectors), .i_loop_count(i_loop_count),
    .o_dut_drive(o_dut_drive), .i_dut_resp(i_dut_resp),
    .o_busy(o_busy), .o_done(o_done), .o_error_count(o_error_count),
    .o_first_err_valid(o_first_err_valid), .o_first_err_addr(o_first_err_addr),
    .o_compare_count(o_compare_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Modelled DUT: response is the drive word delayed by two register stages.
  logic [31:0] r_d1, r_d2;
  always_ff @(posedge i_clk) begin
    r_d1 <= o_dut_drive;
    r_d2 <= r_d1;
  end
  assign i_dut_resp = r_d2;

  int checks = 0;
  int failures = 0;
  logic [31:0] base [4];
  logic [31:0] drv_q [$];

  typedef struct {
    string      nm;
    logic [1:0] md;
    int         nv;
    int         lc;
    logic [3:0] flip;   // expect bit 0 inverted for these vectors
    logic [3:0] m0;     // mask bit 0 cleared for these vectors
    logic [3:0] mz;     // mask all-zero for these vectors
    int         k;      // cycles from start-sample edge to done
    int         err;
    int         fv;
    int         fa;
    int         cmp;
    int         busy;
  } case_t;

  case_t cases [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] flip, input logic [3:0] m0, input logic [3:0] mz);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      i_vec_wr_en     = 1'b1;
      i_vec_wr_addr   = 10'(i);
      i_vec_wr_drive  = base[i];
      i_vec_wr_expect = base[i] ^ {31'b0, flip[i]};
      i_vec_wr_mask   = mz[i] ? 32'h0 : (m0[i] ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end
    @(negedge i_clk);
    i_vec_wr_en = 1'b0;
  endtask

  task automatic run_case(input string nm, input logic [1:0] md, input int nv, input int lc,
                          input bit chk_drv, input int ek, input int eerr, input int efv,
                          input int efa, input int ecmp, input int ebusy);
    int k;
    bit seen_done;
    bit seen_busy;
    logic [31:0] e;
    drv_q.delete();
    if (chk_drv) for (int j = 0; j < ecmp; j++) drv_q.push_back(base[j % nv]);
    @(negedge i_clk);
    i_mode = md;
    i_num_vectors = 11'(nv);
    i_loop_count = 16'(lc);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    k = 0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    while (!seen_done && k <= ek + 50) begin
      if (o_busy) seen_busy = 1'b1;
      if (k >= 1 && drv_q.size() > 0) begin
        e = drv_q.pop_front();
        chk({nm, "/drive"}, o_dut_drive, e);
      end
      if (o_done) seen_done = 1'b1;
      else begin
        @(negedge i_clk);
        k++;
      end
    end
    if (!seen_done) begin
      checks++;
      failures++;
      $display("FAIL %s/timeout done not seen within %0d cycles", nm, ek + 50);
    end else begin
      chk({nm, "/done_cycle"}, k, ek);
    end
    chk({nm, "/drive_left"}, drv_q.size(), 0);
    chk({nm, "/err"}, o_error_count, eerr);
    chk({nm, "/fe_vld"}, o_first_err_valid, efv);
    chk({nm, "/fe_addr"}, o_first_err_addr, efa);
    chk({nm, "/cmp"}, o_compare_count, ecmp);
    chk({nm, "/busy_seen"}, seen_busy, ebusy);
    @(negedge i_clk);
    chk({nm, "/done_pulse"}, o_done, 0);
    chk({nm, "/idle"}, o_busy, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "/drive0"}, o_dut_drive, 0);
    chk({nm, "/busy0"}, o_busy, 0);
    chk({nm, "/done0"}, o_done, 0);
    chk({nm, "/err0"}, o_error_count, 0);
    chk({nm, "/fv0"}, o_first_err_valid, 0);
    chk({nm, "/fa0"}, o_first_err_addr, 0);
    chk({nm, "/cmp0"}, o_compare_count, 0);
  endtask

  initial begin
    int k;
    base[0] = 32'h1357_9BDF;
    base[1] = 32'h2468_ACE0;
    base[2] = 32'hCAFE_F00D;
    base[3] = 32'h0F1E_2D3C;
    //            name         md     nv lc flip     m0       mz       k   err fv fa cmp busy
    cases[0] = '{"single",    2'b00, 4, 1, 4'b0000, 4'b0000, 4'b0000, 7,  0,  0, 0, 4,  1};
    cases[1] = '{"err_v2",    2'b00, 4, 1, 4'b0100, 4'b0000, 4'b0000, 7,  1,  1, 2, 4,  1};
    cases[2] = '{"masked_v2", 2'b00, 4, 1, 4'b0100, 4'b0100, 4'b0000, 7,  0,  0, 0, 4,  1};
    cases[3] = '{"loop3",     2'b01, 4, 3, 4'b0000, 4'b0000, 4'b0000, 15, 0,  0, 0, 12, 1};
    cases[4] = '{"stop",      2'b10, 4, 1, 4'b1010, 4'b0000, 4'b0000, 5,  1,  1, 1, 2,  1};
    cases[5] = '{"loop_stop", 2'b11, 4, 2, 4'b1000, 4'b0000, 4'b0000, 7,  1,  1, 3, 4,  1};
    cases[6] = '{"loop_err",  2'b01, 4, 2, 4'b0001, 4'b0000, 4'b0000, 11, 2,  1, 0, 8,  1};
    cases[7] = '{"mask_zero", 2'b10, 4, 1, 4'b0010, 4'b0000, 4'b0010, 7,  0,  0, 0, 4,  1};
    cases[8] = '{"one_vec",   2'b00, 1, 1, 4'b0000, 4'b0000, 4'b0000, 4,  0,  0, 0, 1,  1};
    cases[9] = '{"zero_vec",  2'b00, 0, 1, 4'b0000, 4'b0000, 4'b0000, 0,  0,  0, 0, 0,  0};

    i_rst = 1'b1;
    i_vec_wr_en = 1'b0;
    i_vec_wr_addr = '0;
    i_vec_wr_drive = '0;
    i_vec_wr_expect = '0;
    i_vec_wr_mask = '0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_mode = '0;
    i_num_vectors = '0;
    i_loop_count = '0;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_rst = 1'b0;

    for (int c = 0; c < 10; c++) begin
      load(cases[c].flip, cases[c].m0, cases[c].mz);
      run_case(cases[c].nm, cases[c].md, cases[c].nv, cases[c].lc, 1'b1, cases[c].k,
               cases[c].err, cases[c].fv, cases[c].fa, cases[c].cmp, cases[c].busy);
    end

    // Writes attempted during RUN must not reach the vector store.
    load(4'b0000, 4'b0000, 4'b0000);
    @(negedge i_clk);
    i_mode = 2'b00;
    i_num_vectors = 11'd4;
    i_loop_count = 16'd1;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    i_vec_wr_en = 1'b1;
    i_vec_wr_addr = 10'd1;
    i_vec_wr_drive = 32'hDEAD_BEEF;
    i_vec_wr_expect = 32'h0;
    i_vec_wr_mask = 32'hFFFF_FFFF;
    repeat (2) @(negedge i_clk);
    i_vec_wr_en = 1'b0;
    k = 0;
    while (!o_done && k < 30) begin
      @(negedge i_clk);
      k++;
    end
    chk("wrbusy/done", o_done, 1);
    run_case("wrbusy_rerun", 2'b00, 4, 1, 1'b1, 7, 0, 0, 0, 4, 1);

    // Endless loop terminated by abort.
    @(negedge i_clk);
    i_mode = 2'b01;
    i_num_vectors = 11'd4;
    i_loop_count = 16'd0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (20) @(negedge i_clk);
    chk("abort/busy_before", o_busy, 1);
    chk("abort/no_done_yet", o_done, 0);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk("abort/done", o_done, 1);
    chk("abort/cmp", o_compare_count, 18);
    chk("abort/err", o_error_count, 0);
    @(negedge i_clk);
    chk("abort/done_pulse", o_done, 0);
    chk("abort/idle", o_busy, 0);

    // Asynchronous reset in the middle of an erroring loop run.
    load(4'b0001, 4'b0000, 4'b0000);
    @(negedge i_clk);
    i_mode = 2'b01;
    i_num_vectors = 11'd4;
    i_loop_count = 16'd0;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (10) @(negedge i_clk);
    chk("rst/pre_busy", o_busy, 1);
    chk("rst/pre_err", o_error_count, 2);
    i_rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(negedge i_clk);
    i_rst = 1'b0;
    load(4'b0000, 4'b0000, 4'b0000);
    run_case("after_rst", 2'b00, 4, 1, 1'b1, 7, 0, 0, 0, 4, 1);

    // Every compare mismatches; 65600 compares must pin the error counter at all-ones.
    load(4'b1111, 4'b0000, 4'b0000);
    run_case("saturate", 2'b01, 4, 16400, 1'b0, 65603, 65535, 1, 0, 65600, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
